// File: rtl/lif_membrane_integrator_if.sv
// Handshake bundle for the LIF integrator: synaptic current input and spike event output.
// The master modport is the engine side, the slave modport is the current source / spike sink.
interface lif_membrane_integrator_if #(
    parameter int VMEM_W = 16,
    parameter int IDX_W  = 3
);
    logic              cur_valid;
    logic              cur_ready;
    logic [VMEM_W-1:0] cur_data;
    logic [IDX_W-1:0]  cur_idx;
    logic              spk_valid;
    logic              spk_ready;
    logic [IDX_W-1:0]  spk_idx;

    modport master (
        input  cur_valid, cur_data, spk_ready,
        output cur_ready, cur_idx, spk_valid, spk_idx
    );

    modport slave (
        input  cur_ready, cur_idx, spk_valid, spk_idx,
        output cur_valid, cur_data, spk_ready
    );
endinterface

// File: rtl/lif_membrane_integrator.sv
// Time-multiplexed LIF membrane update: leak, integrate one current word, fire and write back per neuron.
// Optional feature macro LIF_REFRACTORY_EN adds per-neuron refractory down-counters.
module lif_membrane_integrator #(
    parameter int          VMEM_W = 16,
    parameter int          SHIFT  = 4,
    parameter int          N      = 8,
    parameter int          IDX_W  = 3,
    parameter int unsigned THRESH = 1024,
    parameter int          REFRAC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step_start,
    output logic                   busy,
    output logic                   step_done,
    input  logic [IDX_W-1:0]       dbg_idx,
    output logic [VMEM_W-1:0]      dbg_vmem,
    lif_membrane_integrator_if.master bus
);
    localparam logic [VMEM_W-1:0] THRESH_V = VMEM_W'(THRESH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LEAK     = 3'd2,
        WAIT_CUR = 3'd3,
        INTEG    = 3'd4,
        EMIT     = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [VMEM_W-1:0]   vmem_reg;
    logic [VMEM_W-1:0]   leak_reg;
    logic [VMEM_W-1:0]   cur_reg;

    logic [N-1:0][VMEM_W-1:0] mem_rd;
    logic                     mem_we;
    logic [VMEM_W-1:0]        mem_wdata;

    logic [VMEM_W-1:0]   leak_calc;
    logic [VMEM_W-1:0]   dec;
    logic [VMEM_W:0]     sum_wide;
    logic [VMEM_W-1:0]   sum_sat;
    logic [VMEM_W-1:0]   cur_used;
    logic                refractory;
    logic                fire;

    // Membrane storage: one register per neuron, written only in INTEG for the current index.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mem
            logic [VMEM_W-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (mem_we && (idx_reg == IDX_W'(gi))) begin
                    entry_reg <= mem_wdata;
                end
            end
            assign mem_rd[gi] = entry_reg;
        end
    endgenerate

`ifdef LIF_REFRACTORY_EN
    localparam int RW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
    logic [N-1:0] ref_active;

    generate
        for (gi = 0; gi < N; gi++) begin : g_ref
            logic [RW-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (mem_we && (idx_reg == IDX_W'(gi))) begin
                    if (fire) begin
                        cnt_reg <= RW'(REFRAC);
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - RW'(1);
                    end
                end
            end
            assign ref_active[gi] = (cnt_reg != '0);
        end
    endgenerate

    // A refractory neuron still leaks but its current word is thrown away.
    assign refractory = ref_active[idx_reg];
    assign cur_used   = refractory ? '0 : cur_reg;
`else
    logic unused_refrac;
    assign unused_refrac = (REFRAC != 0);
    assign refractory    = 1'b0;
    assign cur_used      = cur_reg;
`endif

    // Guaranteed-decay leak: any nonzero membrane loses at least 1 per step.
    assign leak_calc = (vmem_reg == '0) ? '0 : ((vmem_reg >> SHIFT) + VMEM_W'(1));
    assign dec       = (vmem_reg > leak_reg) ? (vmem_reg - leak_reg) : '0;
    assign sum_wide  = {1'b0, dec} + {1'b0, cur_used};
    assign sum_sat   = sum_wide[VMEM_W] ? '1 : sum_wide[VMEM_W-1:0];
    assign fire      = (sum_sat >= THRESH_V) && !refractory;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            vmem_reg  <= '0;
            leak_reg  <= '0;
            cur_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (state_reg == FETCH) begin
                vmem_reg <= mem_rd[idx_reg];
            end
            if (state_reg == LEAK) begin
                leak_reg <= leak_calc;
            end
            if ((state_reg == WAIT_CUR) && bus.cur_valid) begin
                cur_reg <= bus.cur_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        mem_we     = 1'b0;
        mem_wdata  = sum_sat;
        case (state_reg)
            IDLE: begin
                if (step_start) begin
                    idx_next   = '0;
                    state_next = FETCH;
                end
            end
            FETCH:    state_next = LEAK;
            LEAK:     state_next = WAIT_CUR;
            WAIT_CUR: begin
                if (bus.cur_valid) begin
                    state_next = INTEG;
                end
            end
            INTEG: begin
                mem_we = 1'b1;
                if (fire) begin
                    mem_wdata  = '0;
                    state_next = EMIT;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = FETCH;
                end
            end
            EMIT: begin
                if (bus.spk_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = FETCH;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All handshake outputs decode directly from state, so a reset clears them at once.
    assign busy          = (state_reg != IDLE);
    assign step_done     = (state_reg == DONE);
    assign bus.cur_ready = (state_reg == WAIT_CUR);
    assign bus.spk_valid = (state_reg == EMIT);
    assign bus.cur_idx   = idx_reg;
    assign bus.spk_idx   = idx_reg;
    assign dbg_vmem      = mem_rd[dbg_idx];

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Directed bench for lif_membrane_integrator: hand-computed sweeps, boundaries, backpressure and reset.
// The refractory section is only compiled when LIF_REFRACTORY_EN is defined.
module tb_lif_membrane_integrator;
    logic        clk;
    logic        rst_n;
    logic        step_start;
    logic        busy;
    logic        step_done;
    logic [2:0]  dbg_idx;
    logic [15:0] dbg_vmem;

    lif_membrane_integrator_if #(.VMEM_W(16), .IDX_W(3)) bus_if ();

    lif_membrane_integrator #(
        .VMEM_W(16), .SHIFT(4), .N(8), .IDX_W(3), .THRESH(1024), .REFRAC(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_start (step_start),
        .busy       (busy),
        .step_done  (step_done),
        .dbg_idx    (dbg_idx),
        .dbg_vmem   (dbg_vmem),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [15:0] cur_vec [8];
    int          busy_cycles;
    int          spk_count;
    logic [7:0]  spk_mask;
    logic [2:0]  first_spk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vmem(input int i, input logic [15:0] exp);
        dbg_idx = 3'(i);
        #1;
        check($sformatf("vmem[%0d]", i), 32'(dbg_vmem), 32'(exp));
    endtask

    task automatic set_cur(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                           input logic [15:0] c3, input logic [15:0] c4, input logic [15:0] c5,
                           input logic [15:0] c6, input logic [15:0] c7);
        cur_vec[0] = c0; cur_vec[1] = c1; cur_vec[2] = c2; cur_vec[3] = c3;
        cur_vec[4] = c4; cur_vec[5] = c5; cur_vec[6] = c6; cur_vec[7] = c7;
    endtask

    // Drives one sweep acting as current source and spike sink; optional stalls, extra start, reset abort.
    task automatic run_step(input int spk_hold, input int hold_idx, input int hold_cycles,
                            input bit abort, input int extra_start_at);
        int         spk_wait;
        int         cur_wait;
        bit         seen_done;
        bit         aborted;
        logic [2:0] held_idx;
        busy_cycles = 0; spk_count = 0; spk_mask = '0; first_spk = '0;
        spk_wait = 0; cur_wait = 0; seen_done = 0; aborted = 0; held_idx = '0;
        @(negedge clk);
        step_start = 1'b1;
        for (int c = 0; c < 300 && !seen_done && !aborted; c++) begin
            @(negedge clk);
            step_start = (c == extra_start_at);
            if (busy) busy_cycles++;
            if (step_done) seen_done = 1;
            bus_if.cur_valid = 1'b0;
            bus_if.spk_ready = 1'b0;
            if (cur_wait > 0 && cur_wait <= hold_cycles && bus_if.cur_idx !== 3'(hold_idx + 1)) begin
                check("cur_stall_ready", 32'(bus_if.cur_ready), 32'd1);
                check("cur_stall_idx", 32'(bus_if.cur_idx), 32'(hold_idx));
            end
            if (spk_wait > 0) begin
                check("spk_stall_valid", 32'(bus_if.spk_valid), 32'd1);
                check("spk_stall_idx", 32'(bus_if.spk_idx), 32'(held_idx));
                check("spk_stall_cur_ready", 32'(bus_if.cur_ready), 32'd0);
            end
            if (bus_if.spk_valid && abort) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_spk_valid", 32'(bus_if.spk_valid), 32'd0);
                check("abort_cur_ready", 32'(bus_if.cur_ready), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check("abort_idle_next", 32'(busy), 32'd0);
                rst_n = 1'b1;
                aborted = 1;
            end else if (bus_if.cur_ready) begin
                if (int'(bus_if.cur_idx) == hold_idx && cur_wait < hold_cycles) begin
                    cur_wait++;
                end else begin
                    bus_if.cur_valid = 1'b1;
                    bus_if.cur_data  = cur_vec[bus_if.cur_idx];
                    if (int'(bus_if.cur_idx) == hold_idx) cur_wait = hold_cycles + 1;
                end
            end else if (bus_if.spk_valid) begin
                if (spk_wait < spk_hold) begin
                    if (spk_wait == 0) held_idx = bus_if.spk_idx;
                    spk_wait++;
                end else begin
                    bus_if.spk_ready = 1'b1;
                    if (spk_count == 0) first_spk = bus_if.spk_idx;
                    spk_mask[bus_if.spk_idx] = 1'b1;
                    spk_count++;
                    spk_wait = 0;
                end
            end
        end
        step_start = 1'b0;
        if (!aborted) begin
            check("step_done_seen", 32'(seen_done), 32'd1);
            @(negedge clk);
            check("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; step_start = 1'b0; dbg_idx = '0;
        bus_if.cur_valid = 1'b0; bus_if.cur_data = '0; bus_if.spk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_ready", 32'(bus_if.cur_ready), 32'd0);
        check("rst_spk_valid", 32'(bus_if.spk_valid), 32'd0);
        check("rst_step_done", 32'(step_done), 32'd0);
        check("rst_cur_idx", 32'(bus_if.cur_idx), 32'd0);
        check("rst_spk_idx", 32'(bus_if.spk_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) check_vmem(i, 16'd0);

        // Step 1: 0 -> 100 everywhere, no spikes, 4N+1 busy cycles.
        set_cur(100, 100, 100, 100, 100, 100, 100, 100);
        run_step(0, -1, 0, 0, -1);
        check("s1_busy_cycles", 32'(busy_cycles), 32'd33);
        check("s1_spikes", 32'(spk_count), 32'd0);
        for (int i = 0; i < 8; i++) check_vmem(i, 16'd100);

        // Step 2: leak of 100 is (100>>4)+1 = 7.
        set_cur(0, 0, 0, 0, 0, 0, 0, 0);
        run_step(0, -1, 0, 0, -1);
        check("s2_busy_cycles", 32'(busy_cycles), 32'd33);
        for (int i = 0; i < 8; i++) check_vmem(i, 16'd93);

        // Reset while a spike from neuron 0 is pending.
        set_cur(2000, 0, 0, 0, 0, 0, 0, 0);
        run_step(100, -1, 0, 1, -1);
        for (int i = 0; i < 8; i++) check_vmem(i, 16'd0);

        // Single fire at neuron 3; a step_start mid-sweep must be dropped.
        set_cur(0, 0, 0, 1100, 0, 0, 0, 0);
        run_step(0, -1, 0, 0, 5);
        check("fire_busy_cycles", 32'(busy_cycles), 32'd34);
        check("fire_count", 32'(spk_count), 32'd1);
        check("fire_idx", 32'(first_spk), 32'd3);
        check("fire_mask", 32'(spk_mask), 32'h08);
        for (int i = 0; i < 8; i++) check_vmem(i, 16'd0);

        // Saturation fires, sum == THRESH fires, THRESH-1 does not.
        set_cur(16'hFFFF, 1024, 1023, 0, 0, 0, 0, 0);
        run_step(0, -1, 0, 0, -1);
        check("sat_busy_cycles", 32'(busy_cycles), 32'd35);
        check("sat_count", 32'(spk_count), 32'd2);
        check("sat_mask", 32'(spk_mask), 32'h03);
        check("sat_first", 32'(first_spk), 32'd0);
        check_vmem(0, 16'd0);
        check_vmem(1, 16'd0);
        check_vmem(2, 16'd1023);

        // Backpressure: spike on 5 held 5 cycles, current for 6 withheld 3 cycles.
        set_cur(0, 0, 0, 0, 0, 2000, 0, 0);
        run_step(5, 6, 3, 0, -1);
        check("bp_busy_cycles", 32'(busy_cycles), 32'd42);
        check("bp_count", 32'(spk_count), 32'd1);
        check("bp_mask", 32'(spk_mask), 32'h20);
        check_vmem(2, 16'd959);
        check_vmem(5, 16'd0);

        // v=1 boundary: leak 1 takes it to exactly 0.
        set_cur(0, 0, 0, 0, 1, 0, 0, 0);
        run_step(0, -1, 0, 0, -1);
        check("v1_busy_cycles", 32'(busy_cycles), 32'd33);
        check_vmem(4, 16'd1);
        check_vmem(2, 16'd899);
        set_cur(0, 0, 0, 0, 0, 0, 0, 0);
        run_step(0, -1, 0, 0, -1);
        check_vmem(4, 16'd0);
        check_vmem(2, 16'd842);

`ifdef LIF_REFRACTORY_EN
        set_cur(2000, 0, 0, 0, 0, 0, 0, 0);
        run_step(0, -1, 0, 0, -1);
        check("ref_fire0", 32'(spk_count), 32'd1);
        run_step(0, -1, 0, 0, -1);
        check("ref_block1", 32'(spk_count), 32'd0);
        check_vmem(0, 16'd0);
        run_step(0, -1, 0, 0, -1);
        check("ref_block2", 32'(spk_count), 32'd0);
        run_step(0, -1, 0, 0, -1);
        check("ref_fire3", 32'(spk_count), 32'd1);
        check("ref_fire3_idx", 32'(first_spk), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lif_membrane_integrator.md
# lif_membrane_integrator

Time-multiplexed LIF membrane update engine for the multi-neuron core: it consumes the leak term on the decay side and turns it into new membrane state and spikes. On each timestep it walks N neurons in index order. For each neuron it fetches the stored membrane potential, computes the guaranteed-decay leak, accepts one synaptic current word over a valid/ready handshake, then integrates and compares against threshold. It writes the result back and emits a spike event over a second valid/ready handshake when a neuron fires.

## Interface
- VMEM_W, 16, membrane/current word width (unsigned)
- SHIFT, 4, leak shift; leak = (v >> SHIFT) + 1 for v != 0, else 0
- N, 8, neuron count (≥2)
- IDX_W, 3, neuron index width, ≥ clog2(N)
- THRESH, 1024, firing threshold (unsigned, VMEM_W bits)
- REFRAC, 2, refractory timesteps (used only with LIF_REFRACTORY_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- step_start  in  1  start one timestep sweep; ignored while busy
- busy  out  1  high from the cycle after an accepted step_start through DONE
- cur_valid  in  1  synaptic current valid
- cur_ready  out  1  engine ready for the current of neuron cur_idx
- cur_data  in  VMEM_W  synaptic current for neuron cur_idx
- cur_idx  out  IDX_W  neuron currently being processed
- spk_valid  out  1  spike event valid
- spk_ready  in  1  spike sink ready
- spk_idx  out  IDX_W  index of the firing neuron
- step_done  out  1  one-cycle pulse when the sweep completes
- dbg_idx  in  IDX_W  debug read address
- dbg_vmem  out  VMEM_W  combinational read of the stored membrane for dbg_idx

## Operation
- Storage: N×VMEM_W register array, vmem_q and leak_q pipeline registers, and the idx counter.
- FSM states: IDLE, FETCH, LEAK, WAIT_CUR, INTEG, EMIT, DONE.
- IDLE: when step_start=1, set idx←0 and go to FETCH.
- FETCH: vmem_q←mem[idx], then go to LEAK.
- LEAK: leak_q←(vmem_q==0) ? 0 : (vmem_q>>SHIFT)+1, then go to WAIT_CUR.
- WAIT_CUR: cur_ready=1. When cur_valid=1, latch cur_data and go to INTEG. Otherwise stay.
- INTEG:
  - dec = vmem_q − leak_q, floored at 0.
  - sum = dec + cur, computed at VMEM_W+1 bits and saturated to all-ones.
  - If sum ≥ THRESH: mem[idx]←0 and go to EMIT.
  - Else: mem[idx]←sum and advance.
- EMIT: spk_valid=1 and spk_idx=idx, held stable until spk_ready=1, then advance.
- Advance: if idx==N−1 go to DONE; else idx←idx+1 and go to FETCH.
- DONE: step_done=1 for one cycle, then go to IDLE.
- cur_ready and spk_valid are never high in the same cycle.
- cur_ready is low outside WAIT_CUR.

## Timing
- Reset values: state IDLE, all mem entries 0, idx 0, busy 0, cur_ready 0, spk_valid 0, spk_idx 0, step_done 0, cur_idx 0.
- Reset takes effect mid-sweep immediately. The partial step is discarded, including any pending spike.
- Per-neuron latency with no stalls: 4 cycles (FETCH, LEAK, WAIT_CUR, INTEG). A spike adds at least 1 EMIT cycle.
- Full sweep with no stalls: 4N + spikes + 1 cycles from the step_start edge to the step_done pulse.
- The mem write in INTEG is visible on dbg_vmem the following cycle.
- step_start while busy is dropped, not queued.
- cur_valid outside WAIT_CUR is ignored.
- Boundaries:
  - v=0: leak is 0.
  - v=1: leak is 1, so dec = 0.
  - sum == THRESH fires.
  - Saturated sum always fires when THRESH ≤ 2^VMEM_W−1.

## Configuration
- LIF_REFRACTORY_EN defined:
  - Adds a per-neuron down-counter, reset to 0.
  - On a spike the neuron's counter loads REFRAC.
  - In INTEG, a neuron with a nonzero counter discards cur (leak still applies), cannot fire, and decrements its counter once per sweep.
  - The handshake is unchanged: the current word is still consumed.
- Undefined: no counters; every neuron integrates every step.

## Test plan
- Reset: drive rst_n low mid-sweep → busy=0, spk_valid=0, all dbg_vmem=0, state IDLE next cycle.
- Leak decay: step 1 with cur=100 for all neurons → all vmem=100, no spikes, sweep length 33 cycles. Step 2 with cur=0 → all vmem=93.
- Fire: cur=1100 to neuron 3, 0 to others → single spike spk_idx=3, vmem[3]=0, others 0.
- Saturation/threshold edge: neuron 0 cur=0xFFFF → spike and vmem 0. Neuron 1 cur=1024 from 0 → spike. Neuron 2 cur=1023 → no spike, vmem 1023.
- Backpressure: spk_ready low 5 cycles during a spike → spk_valid and spk_idx stable, cur_ready=0, sweep resumes on ready. Additionally, cur_valid low 3 cycles → FSM holds in WAIT_CUR.
- Refractory (LIF_REFRACTORY_EN, REFRAC=2): neuron 0 fires, then cur=2000 on the next two steps → no spike. Third step → spike.
